// File: rtl/reg_writeback_unit_pkg.sv
// Shared types for the register write-back slice: word/register types,
// the buffered write-back entry and the CZN flag bit positions.
package reg_writeback_unit_pkg;

  localparam int WB_WIDTH = 8;
  localparam int NUM_REGS = 4;

  typedef logic [WB_WIDTH-1:0] word_t;
  typedef logic [1:0]          reg_idx_t;

  typedef struct packed {
    reg_idx_t dst;
    word_t    data;
    logic     carry;
    logic     setf;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bus bundle between the execute/memory producers and the write-back unit.
// drain_hold stalls the drain side; it is tied low in normal integration.
interface reg_writeback_unit_if;
  import reg_writeback_unit_pkg::*;

  logic     flush;
  logic     drain_hold;
  logic     alu_valid;
  logic     alu_ready;
  reg_idx_t alu_dst;
  word_t    alu_data;
  logic     alu_carry;
  logic     alu_setf;
  logic     mem_valid;
  logic     mem_ready;
  reg_idx_t mem_dst;
  word_t    mem_data;
  reg_idx_t wb_reg;
  word_t    wb_data;
  logic     wb_en;
  logic [2:0] czn;
  reg_idx_t chk_reg1;
  reg_idx_t chk_reg2;
  logic     hazard1;
  logic     hazard2;
  logic [NUM_REGS-1:0] busy;

  modport master (
    output flush, drain_hold, alu_valid, alu_dst, alu_data, alu_carry, alu_setf,
           mem_valid, mem_dst, mem_data, chk_reg1, chk_reg2,
    input  alu_ready, mem_ready, wb_reg, wb_data, wb_en, czn, hazard1, hazard2, busy
  );

  modport slave (
    input  flush, drain_hold, alu_valid, alu_dst, alu_data, alu_carry, alu_setf,
           mem_valid, mem_dst, mem_data, chk_reg1, chk_reg2,
    output alu_ready, mem_ready, wb_reg, wb_data, wb_en, czn, hazard1, hazard2, busy
  );

endinterface

// File: rtl/reg_writeback_unit_chk.sv
// Scoreboard counter checker: a counter never wraps past its ceiling or below zero.
module reg_writeback_unit_chk #(
  parameter int NREG    = 4,
  parameter int CNT_W   = 3,
  parameter int CNT_MAX = 5
) (
  input logic                       clk,
  input logic                       rst,
  input logic [NREG-1:0]            inc,
  input logic [NREG-1:0]            dec,
  input logic [NREG-1:0][CNT_W-1:0] cnt
);

  for (genvar r = 0; r < NREG; r++) begin : g_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(inc[r] && !dec[r] && (cnt[r] == CNT_W'(CNT_MAX))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(dec[r] && !inc[r] && (cnt[r] == {CNT_W{1'b0}})));
  end

endmodule

// File: rtl/reg_writeback_unit_fifo.sv
// In-order synchronous FIFO of write-back entries with a synchronous flush.
// Full/empty come from a registered occupancy count.
module wb_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the registered occupancy
  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    empty     = (count_r == {CNT_W{1'b0}});
    do_push_s = push & ~full & ~flush;
    do_pop_s  = pop & ~empty & ~flush;
    head      = mem_r[rd_ptr_r];
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write side: round-robin ALU/load intake, in-order buffer,
// registered RF write port, CZN flag register and pending-write scoreboard.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WB_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  reg_writeback_unit_if.slave bus
);

  // One extra slot covers the entry sitting in the output register
  localparam int CNT_W = $clog2(DEPTH + 2);

  logic       full_s, empty_s, space_s, grant_mem_s, push_s, pop_s;
  wb_entry_t  push_entry_s, head_s;
  src_t       last_grant_r;
  logic       wb_en_r;
  reg_idx_t   wb_reg_r;
  word_t      wb_data_r;
  logic [2:0] czn_r;
  logic [NUM_REGS-1:0]            inc_s, dec_s, busy_s;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_r;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Round-robin arbitration between ALU and load sources
  always_comb begin
    space_s = ~full_s & ~bus.flush;
    if (bus.alu_valid && bus.mem_valid) begin
      grant_mem_s = (last_grant_r == SRC_ALU);
    end else if (bus.mem_valid) begin
      grant_mem_s = 1'b1;
    end else begin
      grant_mem_s = 1'b0;
    end
    push_s = space_s & (bus.alu_valid | bus.mem_valid);
    if (grant_mem_s) begin
      push_entry_s = '{dst: bus.mem_dst, data: bus.mem_data, carry: 1'b0, setf: 1'b0};
    end else begin
      push_entry_s = '{dst: bus.alu_dst, data: bus.alu_data, carry: bus.alu_carry, setf: bus.alu_setf};
    end
    pop_s = ~empty_s & ~bus.drain_hold & ~bus.flush;
  end

  // Remember which source won the last enqueue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= SRC_ALU;
    end else if (push_s) begin
      last_grant_r <= grant_mem_s ? SRC_MEM : SRC_ALU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // RF write port register and flag update from the popped head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_r   <= 1'b0;
      wb_reg_r  <= 2'b00;
      wb_data_r <= {WB_WIDTH{1'b0}};
      czn_r     <= 3'b000;
    end else if (bus.flush) begin
      wb_en_r <= 1'b0;
    end else if (pop_s) begin
      wb_en_r   <= 1'b1;
      wb_reg_r  <= head_s.dst;
      wb_data_r <= head_s.data;
      if (head_s.setf) begin
        czn_r[FLAG_C] <= head_s.carry;
        czn_r[FLAG_Z] <= (head_s.data == {WB_WIDTH{1'b0}});
        czn_r[FLAG_N] <= head_s.data[WIDTH-1];
      end
    end else begin
      wb_en_r <= 1'b0;
    end
  end

  // Scoreboard increments on enqueue, decrements once the write has been presented
  always_comb begin
    inc_s = {NUM_REGS{1'b0}};
    dec_s = {NUM_REGS{1'b0}};
    if (push_s) begin
      inc_s[push_entry_s.dst] = 1'b1;
    end else begin
      inc_s = {NUM_REGS{1'b0}};
    end
    if (wb_en_r) begin
      dec_s[wb_reg_r] = 1'b1;
    end else begin
      dec_s = {NUM_REGS{1'b0}};
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_s[r] = (cnt_r[r] != {CNT_W{1'b0}});
    end
  end

  // Per-register pending-write counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {(NUM_REGS*CNT_W){1'b0}};
    end else if (bus.flush) begin
      cnt_r <= {(NUM_REGS*CNT_W){1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_s[r] && !dec_s[r]) begin
          cnt_r[r] <= cnt_r[r] + CNT_W'(1);
        end else if (dec_s[r] && !inc_s[r]) begin
          cnt_r[r] <= cnt_r[r] - CNT_W'(1);
        end
      end
    end
  end

  assign bus.alu_ready = space_s & ~grant_mem_s;
  assign bus.mem_ready = space_s & grant_mem_s;
  assign bus.wb_en     = wb_en_r;
  assign bus.wb_reg    = wb_reg_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.czn       = czn_r;
  assign bus.busy      = busy_s;
  assign bus.hazard1   = busy_s[bus.chk_reg1];
  assign bus.hazard2   = busy_s[bus.chk_reg2];

  reg_writeback_unit_chk #(
    .NREG    (NUM_REGS),
    .CNT_W   (CNT_W),
    .CNT_MAX (DEPTH + 1)
  ) u_chk (
    .clk (clk),
    .rst (rst),
    .inc (inc_s),
    .dec (dec_s),
    .cnt (cnt_r)
  );

endmodule
